cordic_sincos_iter: RTL and testbench

Iterative rotation-mode CORDIC that returns signed sine and cosine for a full-circle angle. It performs one micro-rotation per clock, with width, angle resolution and iteration count set by parameters. Input and output both use valid/ready handshakes, including output backpressure. It sits in the DSP datapath as the shared trig engine for NCO/mixer users and replaces the earlier fixed 16-bit, first-quadrant, unsigned-output unit.

---
 rtl/cordic_sincos_iter.sv | 203 ++++++++++++++++++++
 tb/tb_cordic_sincos_iter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sincos_iter.sv
// cordic_sincos_iter: iterative rotation-mode CORDIC returning signed sine and
// cosine (scaled by A = 2^(OUT_W-1)-1) for a full-circle unsigned angle code.
// One micro-rotation per clock; the residual angle inside the quadrant is
// rotated and the result is folded by the latched quadrant on the last cycle.
// Build option: define CORDIC_ROUND_EN to round-half-up when dropping the
// GUARD LSBs; without it the reduction is a plain arithmetic shift (floor).
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. in_ready is high only in IDLE, so theta is sampled once on the
// accept edge. out_valid holds, with sin/cos stable, until out_ready is seen
// high. Both ready signals depend only on state, never on the partner valid.
module cordic_sincos_iter #(
   parameter int OUT_W   = 16,
   parameter int THETA_W = 16,
   parameter int ITERS   = 16,
   parameter int GUARD   = 3
) (
   input  logic                    clk,
   input  logic                    rstb,
   input  logic [THETA_W-1:0]      theta,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] sin,
   output logic signed [OUT_W-1:0] cos,
   output logic [1:0]              dbg_state
);

   localparam int     XW    = OUT_W + GUARD + 2;
   localparam int     ZW    = THETA_W + GUARD;
   localparam int     CW    = $clog2(ITERS);
   localparam int     FRAC  = 40;
   localparam longint PI_FX = 64'sd3454217652357;  // pi * 2^40
   localparam longint AMP   = (longint'(1) << (OUT_W - 1)) - longint'(1);

   // atan(2^-i) expressed in angle-code units * 2^GUARD, rounded.
   // The series x - x^3/3 + ... is exact in shifts because x = 2^-i.
   function automatic longint atan_code(input int i);
      longint acc;
      longint term;
      int     s;
      if (i == 0) return longint'(1) << (ZW - 3);  // pi/4 is one eighth of the circle
      acc = 0;
      for (int k = 0; k < 40; k++) begin
         s = FRAC - i * (2 * k + 1);
         if (s >= 0) begin
            term = (longint'(1) << s) / longint'(2 * k + 1);
            if (k % 2 == 0) acc = acc + term;
            else            acc = acc - term;
         end
      end
      return ((acc << ZW) + PI_FX) / (PI_FX <<< 1);
   endfunction

   // Starting x: round(K * A * 2^GUARD), K = prod 1/sqrt(1 + 2^-2i).
   function automatic longint k_init();
      longint k2;
      longint v;
      longint res;
      longint t;
      k2 = longint'(1) << 30;
      for (int i = 0; i < ITERS; i++)
         k2 = k2 - k2 / ((longint'(1) << (2 * i)) + longint'(1));
      v   = k2 << 30;
      res = 0;
      for (int b = 30; b >= 0; b--) begin
         t = res | (longint'(1) << b);
         if (t * t <= v) res = t;
      end
      return (res * AMP * (longint'(1) << GUARD) + (longint'(1) << 29)) >> 30;
   endfunction

   localparam logic signed [XW-1:0] X0    = XW'(k_init());
   localparam logic signed [XW-1:0] AMP_X = XW'(AMP);
   localparam logic signed [XW-1:0] NEG_X = XW'(-AMP);
`ifdef CORDIC_ROUND_EN
   localparam logic signed [XW-1:0] RND_X = XW'(longint'(1) << (GUARD - 1));
`endif

   // Drop the guard bits and clamp to the symmetric range [-A, +A].
   function automatic logic signed [OUT_W-1:0] reduce_sat(input logic signed [XW-1:0] v);
      logic signed [XW-1:0] r;
`ifdef CORDIC_ROUND_EN
      r = (v + RND_X) >>> GUARD;
`else
      r = v >>> GUARD;
`endif
      if (r > AMP_X)      r = AMP_X;
      else if (r < NEG_X) r = NEG_X;
      return r[OUT_W-1:0];
   endfunction

   typedef enum logic [1:0] {IDLE = 2'd0, ROT = 2'd1, HOLD = 2'd2} state_t;

   state_t                  state, state_nxt;
   logic [CW-1:0]           cnt;
   logic [1:0]              quad;
   logic signed [XW-1:0]    x, y, x_nxt, y_nxt;
   logic signed [ZW-1:0]    z, z_nxt;
   logic signed [ZW-1:0]    atan_tab [ITERS];
   logic signed [XW-1:0]    sin_pre, cos_pre;
   logic signed [OUT_W-1:0] sin_sat, cos_sat;
   logic                    accept, last_iter;

   for (genvar g = 0; g < ITERS; g++) begin : g_atan
      localparam logic signed [ZW-1:0] ATAN_G = ZW'(atan_code(g));
      assign atan_tab[g] = ATAN_G;
   end

   assign accept    = (state == IDLE) && in_valid;
   assign last_iter = (cnt == CW'(ITERS - 1));
   assign dbg_state = state;

   // State register
   always_ff @(posedge clk) begin
      if (rstb) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next state and handshake outputs
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ROT;
         end
         ROT: begin
            if (last_iter) state_nxt = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // One micro-rotation; direction chosen to drive the residual angle to zero
   always_comb begin
      x_nxt = x;
      y_nxt = y;
      z_nxt = z;
      if (!z[ZW-1]) begin
         x_nxt = x - (y >>> cnt);
         y_nxt = y + (x >>> cnt);
         z_nxt = z - atan_tab[cnt];
      end else begin
         x_nxt = x + (y >>> cnt);
         y_nxt = y - (x >>> cnt);
         z_nxt = z + atan_tab[cnt];
      end
   end

   // Quadrant fold of the final rotation result, then reduce and clamp
   always_comb begin
      cos_pre = x_nxt;
      sin_pre = y_nxt;
      unique case (quad)
         2'd0: begin cos_pre = x_nxt;  sin_pre = y_nxt;  end
         2'd1: begin cos_pre = -y_nxt; sin_pre = x_nxt;  end
         2'd2: begin cos_pre = -x_nxt; sin_pre = -y_nxt; end
         2'd3: begin cos_pre = y_nxt;  sin_pre = -x_nxt; end
         default: ;
      endcase
      sin_sat = reduce_sat(sin_pre);
      cos_sat = reduce_sat(cos_pre);
   end

   // Datapath: load on accept, rotate each ROT cycle, register result on the last one
   always_ff @(posedge clk) begin
      if (rstb) begin
         cnt  <= '0;
         quad <= '0;
         x    <= '0;
         y    <= '0;
         z    <= '0;
         sin  <= '0;
         cos  <= '0;
      end else if (accept) begin
         cnt  <= '0;
         quad <= theta[THETA_W-1:THETA_W-2];
         x    <= X0;
         y    <= '0;
         z    <= ZW'(theta[THETA_W-3:0]) << GUARD;
      end else if (state == ROT) begin
         x <= x_nxt;
         y <= y_nxt;
         z <= z_nxt;
         if (last_iter) begin
            cnt <= '0;
            sin <= sin_sat;
            cos <= cos_sat;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_cordic_sincos_iter.sv
// tb_cordic_sincos_iter: self-checking bench for cordic_sincos_iter at default
// parameters. Expected sin/cos come from a real-valued model and are queued at
// accept time; the output monitor pops and compares within +/-TOL LSB.
module tb_cordic_sincos_iter;

   localparam int OUT_W   = 16;
   localparam int THETA_W = 16;
   localparam int ITERS   = 16;
   localparam int GUARD   = 3;
   localparam int TOL     = 3;
   localparam int STEP    = 37;
   localparam logic [15:0] ANGLES [8] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000,
                                          16'h2000, 16'hFFFF, 16'h6000, 16'hA000};

   logic                    clk = 1'b0;
   logic                    rstb = 1'b1;
   logic [THETA_W-1:0]      theta = '0;
   logic                    in_valid = 1'b0;
   logic                    out_ready = 1'b0;
   logic                    in_ready, out_valid;
   logic signed [OUT_W-1:0] dut_sin, dut_cos;
   logic [1:0]              dbg_state;

   int  n_checks = 0;
   int  n_errors = 0;
   int  n_in = 0;
   int  n_out = 0;
   int  max_err = 0;
   real sum_err = 0.0;
   logic [31:0] exp_q[$];

   cordic_sincos_iter #(
      .OUT_W(OUT_W), .THETA_W(THETA_W), .ITERS(ITERS), .GUARD(GUARD)
   ) dut (
      .clk(clk), .rstb(rstb), .theta(theta), .in_valid(in_valid),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .sin(dut_sin), .cos(dut_cos), .dbg_state(dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Ideal result {sin, cos}, each round(A * trig(2*pi*t/2^16))
   function automatic logic [31:0] model(input logic [15:0] t);
      real ang;
      int  s, c;
      ang = 6.283185307179586 * real'(t) / 65536.0;
      s = $rtoi($floor(32767.0 * $sin(ang) + 0.5));
      c = $rtoi($floor(32767.0 * $cos(ang) + 0.5));
      return {s[15:0], c[15:0]};
   endfunction

   // Output monitor: each completed output handshake pops one expected result
   always @(negedge clk) begin
      logic [31:0]      e;
      logic signed [15:0] es, ec;
      int               ds, dc;
      if (!rstb && out_valid && out_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_output: got sin=%0d cos=%0d, required no result", dut_sin, dut_cos);
         end else begin
            e  = exp_q.pop_front();
            es = e[31:16];
            ec = e[15:0];
            ds = iabs(int'(dut_sin) - int'(es));
            dc = iabs(int'(dut_cos) - int'(ec));
            n_out++;
            sum_err = sum_err + real'(ds + dc);
            if (ds > max_err) max_err = ds;
            if (dc > max_err) max_err = dc;
            if (ds > TOL || dc > TOL || dut_sin == -16'sd32768 || dut_cos == -16'sd32768) begin
               n_errors++;
               $display("FAIL result: got sin=%0d cos=%0d, required sin=%0d cos=%0d within %0d and not -32768",
                        dut_sin, dut_cos, es, ec, TOL);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Driver: present theta until accepted, queue its expected result
   task automatic send(input logic [15:0] t);
      int guard = 0;
      theta    = t;
      in_valid = 1'b1;
      while (!in_ready && guard < 200) begin
         tick();
         guard++;
      end
      n_checks++;
      if (!in_ready) begin
         n_errors++;
         $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", guard);
      end else begin
         exp_q.push_back(model(t));
         n_in++;
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rstb = 1'b1;
      repeat (3) tick();
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
      n_checks++; if (dut_sin !== 16'sd0 || dut_cos !== 16'sd0) begin
         n_errors++; $display("FAIL reset_outputs: got sin=%0d cos=%0d, required 0 0", dut_sin, dut_cos);
      end
      n_checks++; if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
      rstb = 1'b0;
      tick();
   endtask

   task automatic test_angles();
      int lat;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         send(ANGLES[k]);
         n_checks++;
         if (dbg_state !== 2'd1 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL rot_state: got state=%0d in_ready=%b, required 1 0", dbg_state, in_ready);
         end
         wait_out(lat);
         n_checks++;
         if (lat != ITERS - 1 + 1 || dbg_state !== 2'd2) begin
            n_errors++;
            $display("FAIL latency: theta=%h got %0d cycles state=%0d, required %0d state=2", ANGLES[k], lat, dbg_state, ITERS);
         end
         if (k == 0) begin
            n_checks++;
            if (dut_cos < 16'sd32764 || dut_sin < -16'sd3 || dut_sin > 16'sd3) begin
               n_errors++;
               $display("FAIL theta0_range: got sin=%0d cos=%0d, required cos 32764..32767 sin -3..3", dut_sin, dut_cos);
            end
         end
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic signed [15:0] hs, hc;
      int lat, bad;
      out_ready = 1'b0;
      send(16'h1234);
      wait_out(lat);
      n_checks++;
      if (!out_valid) begin n_errors++; $display("FAIL bp_timeout: out_valid=0 after %0d cycles, required 1", lat); end
      hs  = dut_sin;
      hc  = dut_cos;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         theta    = 16'($urandom_range(0, 65535));
         in_valid = (k % 2 == 0);
         tick();
         if (dut_sin !== hs || dut_cos !== hc || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_errors++; $display("FAIL hold_stable: got %0d unstable cycles, required 0", bad); end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL release: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
      bad = 0;
      repeat (ITERS + 4) begin
         tick();
         if (out_valid) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_errors++; $display("FAIL busy_ignored: got %0d valid cycles, required 0", bad); end
   endtask

   task automatic test_reset_mid();
      int bad;
      out_ready = 1'b1;
      send(16'h3000);
      repeat (7) tick();
      rstb = 1'b1;
      tick();
      rstb = 1'b0;
      exp_q.delete();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== 2'd0) begin
         n_errors++;
         $display("FAIL abort_handshake: got in_ready=%b out_valid=%b state=%0d, required 1 0 0", in_ready, out_valid, dbg_state);
      end
      n_checks++;
      if (dut_sin !== 16'sd0 || dut_cos !== 16'sd0) begin
         n_errors++; $display("FAIL abort_outputs: got sin=%0d cos=%0d, required 0 0", dut_sin, dut_cos);
      end
      bad = 0;
      repeat (ITERS + 6) begin
         tick();
         if (out_valid) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_errors++; $display("FAIL stale_result: got %0d valid cycles, required 0", bad); end
   endtask

   task automatic test_random();
      int lat;
      for (int k = 0; k < 12; k++) begin
         out_ready = 1'b0;
         send(16'($urandom_range(0, 65535)));
         wait_out(lat);
         repeat ($urandom_range(0, 3)) tick();
         out_ready = 1'b1;
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int  n_in0, n_out0, sent, guard;
      real mean;
      out_ready = 1'b1;
      n_in0   = n_in;
      n_out0  = n_out;
      sum_err = 0.0;
      max_err = 0;
      sent    = 0;
      for (int t = 0; t < 65536; t += STEP) begin
         send(16'(t));
         sent++;
      end
      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         tick();
         guard++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin n_errors++; $display("FAIL drain: got %0d pending, required 0", exp_q.size()); end
      n_checks++;
      if ((n_in - n_in0) != sent || (n_out - n_out0) != sent) begin
         n_errors++;
         $display("FAIL one_to_one: got in=%0d out=%0d, required %0d each", n_in - n_in0, n_out - n_out0, sent);
      end
      n_checks++;
      if (max_err > TOL) begin n_errors++; $display("FAIL max_err: got %0d, required <= %0d", max_err, TOL); end
      mean = sum_err / (2.0 * real'((n_out - n_out0 > 0) ? (n_out - n_out0) : 1));
      n_checks++;
`ifdef CORDIC_ROUND_EN
      if (mean > 1.0) begin n_errors++; $display("FAIL mean_err: got %f, required <= 1.0", mean); end
`else
      if (mean > 2.0) begin n_errors++; $display("FAIL mean_err: got %f, required <= 2.0", mean); end
`endif
   endtask

   initial begin
      test_reset();
      test_angles();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_back_to_back();
      repeat (3) tick();
      n_checks++;
      if (exp_q.size() != 0) begin n_errors++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
